mux21_rr_arbiter: RTL and testbench
===================================

# mux21_rr_arbiter

Two-requester round-robin arbiter that owns the select of a 2:1 datapath mux and registers the selected word into a valid/ready output stage. It sits in front of `mux21`-style selection logic and shares the single output path between requester 1 (`i1` side, `s=0`) and requester 2 (`i2` side, `s=1`). A bounded hold count keeps a streaming requester from starving the other.

## Interface
- `WIDTH`, 8: data width of both inputs and the output.
- `MAX_HOLD`, 4: maximum consecutive accepted beats per grant while the other side is requesting; legal range 1 to 255.

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `req1`, `req2`  in  1  requester i has a word on `di`
- `d1`, `d2`  in  WIDTH  requester data
- `gnt1`, `gnt2`  out  1  registered grant, at most one high
- `ack1`, `ack2`  out  1  combinational; the word on `di` is consumed this cycle
- `s`  out  1  mux select: 0 selects `d1`, 1 selects `d2`
- `o_valid`  out  1  output word valid
- `o_data`  out  WIDTH  registered output word
- `o_ready`  in  1  downstream accepts `o_data` this cycle

## Operation
- States are IDLE, GRANT1 and GRANT2. `gnt1 = (state==GRANT1)`, `gnt2 = (state==GRANT2)`, and `s = (state==GRANT2)`. All three are registered.
- `last` flag holds the most recently granted side.
- `free = ~o_valid | o_ready`.
- `ack_i = gnt_i & req_i & free`.
- On any `ack_i`:
  - `o_data <= s ? d2 : d1`
  - `o_valid <= 1`
  - `cnt <= cnt+1`, saturating at MAX_HOLD
- When `o_valid & o_ready` and there is no ack, `o_valid <= 0` and `o_data` holds its value.
- IDLE:
  - both requesting: grant the side that is not `last`
  - single request: grant that side
  - no request: stay in IDLE
- GRANTx, with the other side called y:
  - `~req_x & req_y`: go to GRANTy
  - `~req_x & ~req_y`: go to IDLE
  - `req_x & req_y` and (`cnt == MAX_HOLD`, or `cnt == MAX_HOLD-1` with an ack this cycle): go to GRANTy
  - otherwise stay
- Every state change clears `cnt` and sets `last` to the newly granted side.
- A switch between GRANT1 and GRANT2 is direct and does not pass through IDLE.
- `cnt` width is `$clog2(MAX_HOLD+1)`. `cnt` never wraps.
- Requesters must hold `req_i` and `d_i` stable until `ack_i`. Dropping `req_i` without an ack is legal and means withdrawal.

## Timing
- Reset values:
  - state IDLE
  - `gnt1 = gnt2 = 0`, `s = 0`
  - `o_valid = 0`, `o_data = 0`
  - `cnt = 0`
  - `last = 2`, so `req1` wins the first tie
- Reset is asynchronous. Asserting it mid-transfer drops `o_valid` and any in-flight word immediately.
- Request to grant: 1 cycle from IDLE. The first ack can occur in the grant cycle.
- Ack to `o_valid`/`o_data`: 1 cycle.
- Throughput: 1 word/cycle while `o_ready = 1`. A fully stalled output (`o_valid & ~o_ready`) blocks all acks, and `cnt` does not advance.
- Switch bubble: the cycle of the last ack on side x is followed by a `gnt_y` cycle in which `ack_y` can already fire. There is no dead cycle.
- Simultaneous output drain and new ack in the same cycle: `o_valid` stays 1 and `o_data` updates.
- `ack_i` is never high unless `gnt_i` is high. `gnt1` and `gnt2` are never high together.

## Structure
- Shared package `mux21_pkg`:
  - state enum `arb_state_t` (IDLE, GRANT1, GRANT2)
  - select constants `SEL_I1 = 1'b0`, `SEL_I2 = 1'b1`
- One sub-module is natural: the existing `mux21` is instantiated per bit (or as WIDTH-wide) with `.s(s)`, feeding the `o_data` register.
- The FSM, `cnt`, `last` and the output stage live in the top module.

## Test plan
All scenarios use WIDTH=8 and MAX_HOLD=4.
- **Reset:** drive `rst_n = 0` mid-run with `o_valid = 1`. Outputs go to 0 immediately. After release with `req1 = req2 = 1` and no other change, `gnt1` is high at the next edge, then `ack1`.
- **Single requester:** `req1 = 1`, `d1` stepping 8'h10..8'h13, `o_ready = 1`. `o_data` shows 10, 11, 12, 13 on consecutive cycles, one cycle after each ack, and `s` stays 0.
- **Fairness:** `req1` and `req2` continuously high, `o_ready = 1`. Beats arrive as 4 from side 1, then 4 from side 2, repeating, with `s` toggling every 4 beats and no idle cycles.
- **Backpressure:** `o_ready = 0` for 5 cycles while `o_valid = 1`. `ack1` and `ack2` stay 0, `o_data` is held, and `cnt` is unchanged. On `o_ready = 1`, the same-cycle drain and ack keep `o_valid` at 1.
- **Withdrawal:** GRANT1 with `req1` dropping after 2 beats and `req2 = 1`. The state is GRANT2 on the next cycle, `cnt` is reset to 0, and `s = 1`.
- **Idle return:** both requests drop. The state returns to IDLE the next cycle, `gnt1 = gnt2 = 0`, and `o_valid` falls after the final `o_ready`.

Source files
------------

// File: rtl/mux21_pkg.sv
// Shared types for the round-robin 2:1 mux arbiter.
// Grant states and mux select encodings.
package mux21_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT1 = 2'd1,
        GRANT2 = 2'd2
    } arb_state_t;

    localparam logic SEL_I1 = 1'b0;
    localparam logic SEL_I2 = 1'b1;

endpackage

// File: rtl/mux21.sv
// WIDTH-wide 2:1 datapath mux.
// s selects i1 (SEL_I1) or i2 (SEL_I2).
module mux21
    import mux21_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic             s,
    output logic [WIDTH-1:0] o
);

    assign o = (s == SEL_I2) ? i2 : i1;

endmodule

// File: rtl/mux21_rr_arbiter.sv
// Two-requester round-robin arbiter driving a 2:1 mux select,
// with a registered valid/ready output stage and bounded hold.
module mux21_rr_arbiter
    import mux21_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req1,
    input  logic             req2,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    output logic             gnt1,
    output logic             gnt2,
    output logic             ack1,
    output logic             ack2,
    output logic             s,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             o_ready
);

    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD);
    localparam logic [CW-1:0] CNT_PRE = CW'(MAX_HOLD - 1);

    arb_state_t       state_q;
    arb_state_t       state_d;
    logic [CW-1:0]    cnt_q;
    logic             last_q;
    logic             free;
    logic             ack;
    logic             hold_done;
    logic             switching;
    logic [WIDTH-1:0] mux_o;

    assign gnt1 = (state_q == GRANT1);
    assign gnt2 = (state_q == GRANT2);
    assign s    = (state_q == GRANT2);

    assign free = ~o_valid | o_ready;
    assign ack1 = gnt1 & req1 & free;
    assign ack2 = gnt2 & req2 & free;
    assign ack  = ack1 | ack2;

    // Hand over when the hold budget is spent, counting this cycle's beat.
    assign hold_done = (cnt_q == CNT_MAX) | ((cnt_q == CNT_PRE) & ack);
    assign switching = (state_d != state_q);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req1 & req2)
                    state_d = (last_q == SEL_I1) ? GRANT2 : GRANT1;
                else if (req1)
                    state_d = GRANT1;
                else if (req2)
                    state_d = GRANT2;
            end
            GRANT1: begin
                if (!req1)
                    state_d = req2 ? GRANT2 : IDLE;
                else if (req2 && hold_done)
                    state_d = GRANT2;
            end
            GRANT2: begin
                if (!req2)
                    state_d = req1 ? GRANT1 : IDLE;
                else if (req1 && hold_done)
                    state_d = GRANT1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= SEL_I2;
        end else begin
            state_q <= state_d;
            if (switching)
                cnt_q <= '0;
            else if (ack && cnt_q != CNT_MAX)
                cnt_q <= cnt_q + CW'(1);
            if (switching && state_d != IDLE)
                last_q <= (state_d == GRANT2) ? SEL_I2 : SEL_I1;
        end
    end

    mux21 #(
        .WIDTH(WIDTH)
    ) u_mux (
        .i1(d1),
        .i2(d2),
        .s (s),
        .o (mux_o)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
        end else if (ack) begin
            o_valid <= 1'b1;
            o_data  <= mux_o;
        end else if (o_valid & o_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux21_rr_arbiter.sv
// Scoreboard bench for mux21_rr_arbiter (WIDTH=8, MAX_HOLD=4).
// Directed requester traffic; a monitor checks each delivered word.
module tb_mux21_rr_arbiter;
    import mux21_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req1, req2;
    logic [7:0] d1, d2;
    logic       gnt1, gnt2, ack1, ack2, s;
    logic       o_valid;
    logic [7:0] o_data;
    logic       o_ready;

    int n_cmp = 0;
    int n_err = 0;
    int n1, n2;
    logic la1, la2;
    logic [7:0] sb[$];

    mux21_rr_arbiter #(
        .WIDTH(8),
        .MAX_HOLD(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req1(req1), .req2(req2),
        .d1(d1), .d2(d2),
        .gnt1(gnt1), .gnt2(gnt2),
        .ack1(ack1), .ack2(ack2),
        .s(s),
        .o_valid(o_valid), .o_data(o_data),
        .o_ready(o_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every delivered word must match the scoreboard head.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("protocol", {30'd0, gnt1 & gnt2,
                (ack1 & ~gnt1) | (ack2 & ~gnt2)}, 32'd0);
            if (o_valid && o_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_word", {24'd0, o_data}, 32'hffff_ffff);
                end else begin
                    chk("o_data", {24'd0, o_data}, {24'd0, sb.pop_front()});
                end
            end
        end
    end

    // One clock; requesters advance their word on ack.
    task automatic cyc();
        @(negedge clk);
        la1 = ack1;
        la2 = ack2;
        @(posedge clk);
        #1;
        if (la1) begin d1 = d1 + 8'd1; n1--; req1 = (n1 > 0); end
        if (la2) begin d2 = d2 + 8'd1; n2--; req2 = (n2 > 0); end
    endtask

    task automatic push_run(logic [7:0] base, int n);
        for (int i = 0; i < n; i++) sb.push_back(base + 8'(i));
    endtask

    initial begin
        int cyc_cnt, beats;
        rst_n = 1'b0;
        req1 = 0; req2 = 0; d1 = 0; d2 = 0; o_ready = 1'b1;
        n1 = 0; n2 = 0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_gnt", {30'd0, gnt1, gnt2}, 32'd0);
        chk("rst_s", {31'd0, s}, 32'd0);
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_data", {24'd0, o_data}, 32'd0);

        // Single requester on side 1
        d1 = 8'h10; n1 = 4; req1 = 1;
        push_run(8'h10, 4);
        cyc_cnt = 0;
        while (n1 > 0 && cyc_cnt < 20) begin
            cyc();
            cyc_cnt++;
            chk("single_s", {31'd0, s}, 32'd0);
        end
        chk("single_len", cyc_cnt, 5);
        cyc();
        chk("single_idle", {30'd0, gnt1, gnt2}, 32'd0);

        // Fairness: last grant was side 1, so side 2 leads
        d1 = 8'h30; n1 = 8; req1 = 1;
        d2 = 8'h40; n2 = 8; req2 = 1;
        push_run(8'h40, 4); push_run(8'h30, 4);
        push_run(8'h44, 4); push_run(8'h34, 4);
        cyc_cnt = 0; beats = 0;
        while (beats < 16 && cyc_cnt < 40) begin
            cyc();
            cyc_cnt++;
            if (la1 | la2) beats++;
        end
        chk("fair_cycles", cyc_cnt, 17);
        cyc(); cyc();

        // Backpressure
        d1 = 8'h50; n1 = 3; req1 = 1;
        push_run(8'h50, 3);
        cyc_cnt = 0;
        while (!o_valid && cyc_cnt < 10) begin cyc(); cyc_cnt++; end
        chk("bp_valid", {31'd0, o_valid}, 32'd1);
        o_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp_ack", {30'd0, la1, la2}, 32'd0);
            chk("bp_hold", {24'd0, o_data}, 32'h50);
            chk("bp_cnt", 32'(dut.cnt_q), 32'd1);
        end
        o_ready = 1'b1;
        cyc();
        chk("bp_resume_ack", {31'd0, la1}, 32'd1);
        chk("bp_resume_valid", {31'd0, o_valid}, 32'd1);
        chk("bp_resume_data", {24'd0, o_data}, 32'h51);
        cyc_cnt = 0;
        while (n1 > 0 && cyc_cnt < 10) begin cyc(); cyc_cnt++; end
        cyc(); cyc();

        // Withdrawal: side 1 leaves after 2 beats, side 2 waiting
        d1 = 8'h60; n1 = 2; req1 = 1;
        push_run(8'h60, 2); push_run(8'h70, 2);
        cyc();
        chk("wd_gnt1", {31'd0, gnt1}, 32'd1);
        d2 = 8'h70; n2 = 2; req2 = 1;
        cyc_cnt = 0;
        while (!gnt2 && cyc_cnt < 10) begin cyc(); cyc_cnt++; end
        chk("wd_cycles", cyc_cnt, 3);
        chk("wd_state", 32'(dut.state_q), 32'(GRANT2));
        chk("wd_cnt", 32'(dut.cnt_q), 32'd0);
        chk("wd_s", {31'd0, s}, 32'd1);

        // Idle return
        cyc_cnt = 0;
        while (n2 > 0 && cyc_cnt < 10) begin cyc(); cyc_cnt++; end
        chk("idle_valid_last", {31'd0, o_valid}, 32'd1);
        cyc();
        chk("idle_state", 32'(dut.state_q), 32'(IDLE));
        chk("idle_gnt", {30'd0, gnt1, gnt2}, 32'd0);
        chk("idle_valid", {31'd0, o_valid}, 32'd0);

        // Asynchronous reset with a word in flight
        d1 = 8'h80; n1 = 4; req1 = 1;
        cyc_cnt = 0;
        while (!o_valid && cyc_cnt < 10) begin cyc(); cyc_cnt++; end
        #1 rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, o_valid}, 32'd0);
        chk("arst_data", {24'd0, o_data}, 32'd0);
        chk("arst_gnt", {29'd0, gnt1, gnt2, s}, 32'd0);
        sb.delete();
        d1 = 8'h90; n1 = 1; req1 = 1;
        d2 = 8'ha0; n2 = 1; req2 = 1;
        push_run(8'h90, 1); push_run(8'ha0, 1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        cyc();
        chk("arst_gnt1", {30'd0, gnt1, gnt2}, 32'b10);
        chk("arst_ack1", {30'd0, ack1, ack2}, 32'b10);

        cyc_cnt = 0;
        while (sb.size() > 0 && cyc_cnt < 20) begin cyc(); cyc_cnt++; end
        chk("sb_drain", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
